// File: rtl/load_writeback_unit_pkg.sv
// Shared RV32 definitions for the load path: funct3 encodings, load FSM states, widths.
// Also holds the legality/alignment helpers used by the load writeback unit.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    ERR  = 2'd3
  } load_state_t;

  function automatic logic load_f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    return (((f3 == F3_LH) || (f3 == F3_LHU)) && lane[0]) ||
           ((f3 == F3_LW) && (lane != 2'b00));
  endfunction

endpackage

// File: rtl/load_writeback_unit_if.sv
// Signal bundle between control FSM / data memory / register file and the load unit.
// Handshake: start is a one-cycle command sampled only while busy=0; mem_req holds until mem_ack.
interface load_writeback_unit_if;
  import riscv_pkg::*;

  logic                  start;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       addr;
  logic [REG_ADDR_W-1:0] rd;
  logic                  mem_req;
  logic [XLEN-1:0]       mem_addr;
  logic                  mem_ack;
  logic [XLEN-1:0]       mem_rdata;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_address;
  logic [XLEN-1:0]       write_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    output start, funct3, addr, rd, mem_ack, mem_rdata,
    input  mem_req, mem_addr, reg_write, write_address, write_data, busy, done, err
  );

  modport slave (
    input  start, funct3, addr, rd, mem_ack, mem_rdata,
    output mem_req, mem_addr, reg_write, write_address, write_data, busy, done, err
  );

endinterface

// File: rtl/load_data_align.sv
// Combinational lane select and sign/zero extension of a loaded word.
// Shared with the store path tests, so it stays free of any FSM context.
module load_data_align
  import riscv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_lane,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_lane)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_writeback_unit.sv
// Multi-cycle load unit: one command -> aligned memory read -> extended register writeback.
// Optional REQ timeout abort is built when LOAD_TIMEOUT_EN is defined.
module load_writeback_unit
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  load_writeback_unit_if.slave bus,
  output load_state_t          o_state
);

  if ((2 ** CNT_W) <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  load_state_t           r_state;
  logic [2:0]            r_funct3_q;
  logic [XLEN-1:0]       r_addr_q;
  logic [REG_ADDR_W-1:0] r_rd_q;
  logic [XLEN-1:0]       r_data_q;
  logic                  r_mem_req;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_write_address;
  logic                  r_done;
  logic                  r_err;
  logic [XLEN-1:0]       w_ext;
`ifdef LOAD_TIMEOUT_EN
  logic [CNT_W-1:0]      r_cnt;
`endif

  load_data_align u_align (
    .i_funct3 (r_funct3_q),
    .i_lane   (r_addr_q[1:0]),
    .i_rdata  (bus.mem_rdata),
    .o_data   (w_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_funct3_q      <= '0;
      r_addr_q        <= '0;
      r_rd_q          <= '0;
      r_data_q        <= '0;
      r_mem_req       <= 1'b0;
      r_reg_write     <= 1'b0;
      r_write_address <= '0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      r_cnt           <= '0;
`endif
    end else begin
      r_reg_write <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_funct3_q <= bus.funct3;
            r_addr_q   <= bus.addr;
            r_rd_q     <= bus.rd;
            // Bad commands are rejected before any memory traffic.
            if (!load_f3_legal(bus.funct3) || load_misaligned(bus.funct3, bus.addr[1:0])) begin
              r_state <= ERR;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state   <= REQ;
              r_mem_req <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
              r_cnt     <= '0;
`endif
            end
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            // x0 is not write-protected in the register file, so suppress its write here.
            r_data_q        <= w_ext;
            r_write_address <= r_rd_q;
            r_reg_write     <= (r_rd_q != '0);
            r_done          <= 1'b1;
            r_mem_req       <= 1'b0;
            r_state         <= WB;
          end
`ifdef LOAD_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
            r_state   <= ERR;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        WB:      r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req       = r_mem_req;
  assign bus.mem_addr      = {r_addr_q[XLEN-1:2], 2'b00};
  assign bus.reg_write     = r_reg_write;
  assign bus.write_address = r_write_address;
  assign bus.write_data    = r_data_q;
  assign bus.busy          = (r_state != IDLE);
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign o_state           = r_state;

endmodule
